dot_product_controller: RTL and testbench
=========================================

# dot_product_controller

Sequencer for the dot-product input memory wrapper. It accepts operand pairs on a valid/ready stream and writes them into both operand memories, then pulses `start_reading`. It multiply-accumulates the element pairs the reader streams back and presents the scalar result on a valid/ready output. It sits between the upstream operand source and the input memory wrapper, and owns every control input of that wrapper.

## Interface
- `DATA_WIDTH`, 8: operand width; operands are unsigned.
- `VECTOR_WIDTH`, 4: elements per vector.
- `ADDR_WIDTH`, 5: memory address width.
- `ACC_WIDTH`, 2*DATA_WIDTH+$clog2(VECTOR_WIDTH) (18): accumulator and result width.
- `TIMEOUT`, 64: READ-state watchdog limit, in cycles.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: controller accepts the pair.
- `in_a`, `in_b` in DATA_WIDTH: operand pair.
- `write_en` out 1: memory write strobe.
- `write_addr` out ADDR_WIDTH: memory write address.
- `data_a`, `data_b` out DATA_WIDTH: memory write data.
- `start_reading` out 1: one-cycle reader kick.
- `data_valid` in 1: reader outputs valid this cycle.
- `mem1_output`, `mem2_output` in DATA_WIDTH: element pair from the reader.
- `reading_done` in 1: reader finished.
- `res_valid` out 1: result held.
- `res_ready` in 1: result consumed.
- `res_data` out ACC_WIDTH: dot product.
- `res_err` out 1: result ended by timeout or by a short read.
- `busy` out 1: high in every state except LOAD.

## Operation
- States: LOAD, KICK, READ, RESULT. Reset state is LOAD.
- **LOAD**
  - `in_ready`=1.
  - On handshake (`in_valid && in_ready`): `write_en`=1, `write_addr`=`load_cnt`, and `data_a`/`data_b` = `in_a`/`in_b`, all combinational in the same cycle. `load_cnt` then increments.
  - The handshake that accepts element VECTOR_WIDTH-1 moves the state to KICK.
- **KICK** (exactly 1 cycle)
  - `start_reading`=1.
  - Accumulator, `rd_cnt` and the watchdog counter clear.
  - Next state: READ.
- **READ**
  - Each cycle with `data_valid`=1: acc += `mem1_output`*`mem2_output` (full-width unsigned product, zero-extended to ACC_WIDTH), and `rd_cnt` increments.
  - When `reading_done`=1: go to RESULT. `res_err` = (`rd_cnt` after this cycle's update != VECTOR_WIDTH).
  - `data_valid` and `reading_done` in the same cycle: the product is included before the result is registered.
  - Watchdog increments every READ cycle. On reaching TIMEOUT without `reading_done`, go to RESULT with `res_err`=1 and the partial sum as `res_data`.
  - `data_valid` in any other state is ignored.
- **RESULT**
  - `res_valid`=1; `res_data` and `res_err` are held stable until `res_ready`.
  - On `res_valid && res_ready`: go to LOAD with `load_cnt`=0.
- `in_ready`=0 in KICK, READ and RESULT.
- Accumulator overflow cannot occur for VECTOR_WIDTH products at the default ACC_WIDTH. Smaller overridden ACC_WIDTH values wrap modulo 2^ACC_WIDTH.
- Asserting `rst_n` in any state aborts immediately. Memory contents are left untouched, and the next load overwrites them.

## Timing
- Reset values:
  - `in_ready`=1
  - `write_en`=0, `write_addr`=0, `data_a`=0, `data_b`=0
  - `start_reading`=0
  - `res_valid`=0, `res_data`=0, `res_err`=0
  - `busy`=0
- `write_en`, `write_addr`, `data_a` and `data_b` are combinational from the handshake. All other outputs are registered or decoded from the state register.
- `start_reading` rises in the cycle after the last accepted pair.
- `res_valid` rises in the cycle after `reading_done` is sampled.
- Back-to-back operation: LOAD is re-entered in the cycle after the result handshake, and `in_ready`=1 in that cycle.
- Minimum turnaround per vector: VECTOR_WIDTH load cycles, plus 1 KICK cycle, plus the reader latency, plus 1 RESULT cycle.

## Structure
- Package `dot_product_pkg` holds:
  - the state enum `ctrl_state_t`;
  - a function `acc_width(data_w, vec_w)`;
  - the shared default constants DATA_WIDTH, VECTOR_WIDTH and ADDR_WIDTH.
- Sub-module `mac_accumulator` (clear, enable, a, b → acc) isolates the multiply-add, so a later pipelined version can replace it.
- The FSM, load counter and watchdog stay in the top module.

## Test plan
- Load a=[1,2,3,4], b=[5,6,7,8] against the real wrapper → writes to addresses 0..3, one `start_reading` pulse, `res_data`=70, `res_err`=0.
- Load all operands 255 → `res_data`=260100, `res_err`=0, no wrap.
- Stall: gaps in `in_valid` during LOAD, and `res_ready` low for 10 cycles → result held stable, `in_ready`=0 throughout the stall, exactly 4 writes.
- Reader model asserts `data_valid` and `reading_done` together on the 4th element → final product included, `res_err`=0. Asserting `reading_done` after 3 elements → `res_err`=1 with the 3-term sum.
- Reader model never asserts `reading_done` → RESULT entered after 64 READ cycles with `res_err`=1.
- Assert `rst_n` low mid-READ, then run a fresh vector [2,2,2,2]·[3,3,3,3] → all outputs at reset values, then `res_data`=24.

Source files
------------

// File: rtl/dot_product_pkg.sv
// Shared types and defaults for the dot-product controller and its datapath.
package dot_product_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned VECTOR_WIDTH = 4;
  localparam int unsigned ADDR_WIDTH   = 5;

  typedef enum logic [1:0] {
    StLoad,
    StKick,
    StRead,
    StResult
  } ctrl_state_t;

  // Wide enough to hold vec_w full-width products without wrap.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned vec_w);
    return 2 * data_w + $clog2(vec_w);
  endfunction

endpackage

// File: rtl/mac_accumulator.sv
// Unsigned multiply-accumulate register; kept separate so a pipelined MAC can drop in.
module mac_accumulator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam int unsigned SumW  = (ACC_WIDTH > ProdW) ? ACC_WIDTH : ProdW;

  logic [ProdW-1:0]     prod;
  logic [SumW-1:0]      sum;
  logic [ACC_WIDTH-1:0] acc_d, acc_q;

  assign prod = ProdW'(a) * ProdW'(b);
  // Narrow accumulators simply wrap modulo 2^ACC_WIDTH.
  assign sum  = SumW'(acc_q) + SumW'(prod);

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = sum[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dot_product_controller.sv
// Loads operand pairs into the input memories, kicks the reader, accumulates the
// streamed element products and holds the scalar result until it is consumed.
module dot_product_controller #(
  parameter int unsigned DATA_WIDTH   = dot_product_pkg::DATA_WIDTH,
  parameter int unsigned VECTOR_WIDTH = dot_product_pkg::VECTOR_WIDTH,
  parameter int unsigned ADDR_WIDTH   = dot_product_pkg::ADDR_WIDTH,
  parameter int unsigned ACC_WIDTH    = dot_product_pkg::acc_width(DATA_WIDTH, VECTOR_WIDTH),
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  start_reading,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] mem1_output,
  input  logic [DATA_WIDTH-1:0] mem2_output,
  input  logic                  reading_done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_err,
  output logic                  busy
);
  import dot_product_pkg::*;

  localparam int unsigned LoadW  = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam int unsigned CntMax = (TIMEOUT > VECTOR_WIDTH) ? TIMEOUT : VECTOR_WIDTH;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [LoadW-1:0] LoadLast = LoadW'(VECTOR_WIDTH - 1);
  localparam logic [CntW-1:0]  RdTarget = CntW'(VECTOR_WIDTH);
  localparam logic [CntW-1:0]  WdLast   = CntW'(TIMEOUT - 1);

  ctrl_state_t      state_d, state_q;
  logic [LoadW-1:0] load_cnt_d, load_cnt_q;
  logic [CntW-1:0]  rd_cnt_d, rd_cnt_q, rd_cnt_upd;
  logic [CntW-1:0]  wd_cnt_d, wd_cnt_q;
  logic             res_err_d, res_err_q;
  logic             handshake;
  logic             acc_clear, acc_en;

  assign in_ready   = (state_q == StLoad);
  assign handshake  = in_valid && in_ready;
  assign rd_cnt_upd = rd_cnt_q + CntW'(data_valid);

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    res_err_d  = res_err_q;
    acc_clear  = 1'b0;
    acc_en     = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (handshake) begin
          if (load_cnt_q == LoadLast) begin
            load_cnt_d = '0;
            state_d    = StKick;
          end else begin
            load_cnt_d = load_cnt_q + LoadW'(1);
          end
        end
      end
      StKick: begin
        acc_clear = 1'b1;
        rd_cnt_d  = '0;
        wd_cnt_d  = '0;
        res_err_d = 1'b0;
        state_d   = StRead;
      end
      StRead: begin
        acc_en   = data_valid;
        rd_cnt_d = rd_cnt_upd;
        wd_cnt_d = wd_cnt_q + CntW'(1);
        // A final element arriving with reading_done still counts toward the check.
        if (reading_done) begin
          state_d   = StResult;
          res_err_d = (rd_cnt_upd != RdTarget);
        end else if (wd_cnt_q == WdLast) begin
          state_d   = StResult;
          res_err_d = 1'b1;
        end
      end
      StResult: begin
        if (res_ready) begin
          state_d    = StLoad;
          load_cnt_d = '0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      load_cnt_q <= '0;
      rd_cnt_q   <= '0;
      wd_cnt_q   <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      res_err_q  <= res_err_d;
    end
  end

  mac_accumulator #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (acc_clear),
    .enable(acc_en),
    .a     (mem1_output),
    .b     (mem2_output),
    .acc   (res_data)
  );

  assign write_en      = handshake;
  assign write_addr    = handshake ? ADDR_WIDTH'(load_cnt_q) : '0;
  assign data_a        = handshake ? in_a : '0;
  assign data_b        = handshake ? in_b : '0;
  assign start_reading = (state_q == StKick);
  assign res_valid     = (state_q == StResult);
  assign res_err       = res_err_q;
  assign busy          = (state_q != StLoad);

endmodule

// File: tb/tb_dot_product_controller.sv
// Directed bench: loads vectors, models the memory reader and checks the results.
module tb_dot_product_controller;

  localparam int unsigned DW  = 8;
  localparam int unsigned VW  = 4;
  localparam int unsigned AW  = 5;
  localparam int unsigned AccW = 18;

  localparam int ModeDoneWithLast = 0;
  localparam int ModeDoneAfter    = 1;
  localparam int ModeNever        = 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a, in_b;
  logic            write_en;
  logic [AW-1:0]   write_addr;
  logic [DW-1:0]   data_a, data_b;
  logic            start_reading;
  logic            data_valid;
  logic [DW-1:0]   mem1_output, mem2_output;
  logic            reading_done;
  logic            res_valid;
  logic            res_ready;
  logic [AccW-1:0] res_data;
  logic            res_err;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];
  int wr_count   = 0;
  int kick_count = 0;

  dot_product_controller #(
    .DATA_WIDTH  (DW),
    .VECTOR_WIDTH(VW),
    .ADDR_WIDTH  (AW),
    .ACC_WIDTH   (AccW),
    .TIMEOUT     (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .write_en     (write_en),
    .write_addr   (write_addr),
    .data_a       (data_a),
    .data_b       (data_b),
    .start_reading(start_reading),
    .data_valid   (data_valid),
    .mem1_output  (mem1_output),
    .mem2_output  (mem2_output),
    .reading_done (reading_done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_err      (res_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the operand memories.
  always @(posedge clk) begin
    if (write_en) begin
      mem_a[write_addr] <= data_a;
      mem_b[write_addr] <= data_b;
      wr_count <= wr_count + 1;
    end
    if (start_reading) kick_count <= kick_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " in_ready"}, 32'(in_ready), 1);
    check({tag, " write_en"}, 32'(write_en), 0);
    check({tag, " write_addr"}, 32'(write_addr), 0);
    check({tag, " data_a"}, 32'(data_a), 0);
    check({tag, " data_b"}, 32'(data_b), 0);
    check({tag, " start_reading"}, 32'(start_reading), 0);
    check({tag, " res_valid"}, 32'(res_valid), 0);
    check({tag, " res_data"}, 32'(res_data), 0);
    check({tag, " res_err"}, 32'(res_err), 0);
    check({tag, " busy"}, 32'(busy), 0);
  endtask

  // Offers VW pairs (optionally with an idle cycle before each) and checks the write strobe.
  task automatic load_vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input bit gaps);
    for (int i = 0; i < VW; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        #1;
        check({tag, " gap in_ready"}, 32'(in_ready), 1);
        check({tag, " gap write_en"}, 32'(write_en), 0);
        step();
      end
      in_valid = 1'b1;
      in_a     = av[i*8 +: 8];
      in_b     = bv[i*8 +: 8];
      #1;
      check({tag, " write_en"}, 32'(write_en), 1);
      check({tag, " write_addr"}, 32'(write_addr), 32'(i));
      check({tag, " data_a"}, 32'(data_a), 32'(av[i*8 +: 8]));
      check({tag, " data_b"}, 32'(data_b), 32'(bv[i*8 +: 8]));
      step();
    end
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    #1;
    check({tag, " start_reading"}, 32'(start_reading), 1);
    check({tag, " busy kick"}, 32'(busy), 1);
    check({tag, " in_ready kick"}, 32'(in_ready), 0);
  endtask

  // Called in the KICK cycle; streams nelem elements and returns cycles until res_valid.
  task automatic read_vec(input int mode, input int nelem, output int lat);
    int t;
    t = 0;
    while (t < 200) begin
      step();
      t++;
      if (res_valid) break;
      data_valid   = (t <= nelem);
      mem1_output  = (t <= nelem) ? mem_a[t-1] : '0;
      mem2_output  = (t <= nelem) ? mem_b[t-1] : '0;
      reading_done = (mode == ModeDoneWithLast && t == nelem) ||
                     (mode == ModeDoneAfter && t == nelem + 1);
    end
    data_valid   = 1'b0;
    reading_done = 1'b0;
    mem1_output  = '0;
    mem2_output  = '0;
    lat = t;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input bit gaps, input int mode, input int nelem, input int stall,
                         input int exp_lat, input logic [31:0] exp_data, input bit exp_err);
    int w0, k0, lat;
    w0 = wr_count;
    k0 = kick_count;
    load_vec(tag, av, bv, gaps);
    read_vec(mode, nelem, lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " res_valid"}, 32'(res_valid), 1);
    check({tag, " res_data"}, 32'(res_data), exp_data);
    check({tag, " res_err"}, 32'(res_err), 32'(exp_err));
    check({tag, " writes"}, 32'(wr_count - w0), 4);
    check({tag, " kicks"}, 32'(kick_count - k0), 1);
    for (int s = 0; s < stall; s++) begin
      step();
      check({tag, " stall res_valid"}, 32'(res_valid), 1);
      check({tag, " stall res_data"}, 32'(res_data), exp_data);
      check({tag, " stall res_err"}, 32'(res_err), 32'(exp_err));
      check({tag, " stall in_ready"}, 32'(in_ready), 0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, " reload in_ready"}, 32'(in_ready), 1);
    check({tag, " reload busy"}, 32'(busy), 0);
    check({tag, " reload res_valid"}, 32'(res_valid), 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    data_valid   = 1'b0;
    mem1_output  = '0;
    mem2_output  = '0;
    reading_done = 1'b0;
    res_ready    = 1'b0;
    #2;
    check_reset_values("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Vectors packed element 3..0, MSB first.
    run_vec("basic", 32'h04030201, 32'h08070605, 1'b0, ModeDoneWithLast, 4, 0, 5, 70, 1'b0);
    run_vec("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, ModeDoneAfter, 4, 0, 6, 260100, 1'b0);
    run_vec("stall", 32'h04030201, 32'h08070605, 1'b1, ModeDoneAfter, 4, 10, 6, 70, 1'b0);
    run_vec("short", 32'h04030201, 32'h08070605, 1'b0, ModeDoneAfter, 3, 0, 5, 38, 1'b1);
    run_vec("timeout", 32'h04030201, 32'h08070605, 1'b0, ModeNever, 4, 0, 65, 70, 1'b1);

    // Abort mid-read, then a fresh vector must start from a clean slate.
    load_vec("abort", 32'h01010101, 32'h09090909, 1'b0);
    step();
    data_valid  = 1'b1;
    mem1_output = 8'd1;
    mem2_output = 8'd9;
    step();
    data_valid  = 1'b0;
    mem1_output = '0;
    mem2_output = '0;
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    step();
    rst_n = 1'b1;
    step();
    run_vec("fresh", 32'h02020202, 32'h03030303, 1'b0, ModeDoneWithLast, 4, 0, 5, 24, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
